// File: rtl/dp_param_pkg.sv
// rtl/dp_param_pkg.sv - shared opcodes, flag indices and bench clock period for dp_param
package dp_param_pkg;

   // ALU opcodes
   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_AND  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_NOT  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_INC  = 3'b110;
   localparam logic [2:0] ALU_DEC  = 3'b111;

   // Shifter opcodes
   localparam logic [1:0] SH_PASS = 2'b00;
   localparam logic [1:0] SH_SHL  = 2'b01;
   localparam logic [1:0] SH_SHR  = 2'b10;
   localparam logic [1:0] SH_ROR  = 2'b11;

   // Bit positions inside flags = {Z, N, C, V}
   localparam int F_Z = 3;
   localparam int F_N = 2;
   localparam int F_C = 1;
   localparam int F_V = 0;

   // Half clock period used by benches
   localparam int HALF = 5;

endpackage

// File: rtl/dp_regfile.sv
// rtl/dp_regfile.sv - DEPTH x WIDTH register file, one sync write port, two enabled comb read ports
module dp_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             we_i,
   input  logic [AW-1:0]    wa_i,
   input  logic [WIDTH-1:0] wd_i,
   input  logic             rae_i,
   input  logic [AW-1:0]    raa_i,
   input  logic             rbe_i,
   input  logic [AW-1:0]    rba_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage: cleared asynchronously, written on the rising edge when enabled
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[wa_i] <= wd_i;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write is not forwarded
   assign a_o = rae_i ? mem_q[raa_i] : '0;
   assign b_o = rbe_i ? mem_q[rba_i] : '0;

endmodule

// File: rtl/dp_param.sv
// rtl/dp_param.sv - parametrised register-file datapath with ALU, shifter, flags and registered output
module dp_param
   import dp_param_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] n_input,
   input  logic             IE,
   input  logic             WE,
   input  logic [AW-1:0]    WA,
   input  logic             RAE,
   input  logic [AW-1:0]    RAA,
   input  logic             RBE,
   input  logic [AW-1:0]    RBA,
   input  logic [2:0]       ALU,
   input  logic [1:0]       SH,
   input  logic             OE,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             n_is_0,
   output logic [3:0]       flags
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             arith;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_y;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH-1:0] sh_y;
   logic [3:0]       flags_q, flags_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;

   dp_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
      .clock  (clock),
      .reset_n(reset_n),
      .we_i   (WE),
      .wa_i   (WA),
      .wd_i   (wd),
      .rae_i  (RAE),
      .raa_i  (RAA),
      .rbe_i  (RBE),
      .rba_i  (RBA),
      .a_o    (a),
      .b_o    (b)
   );

   // Adder operand select: every arithmetic op is A + op_b + cin on one adder
   always_comb begin
      op_b  = '0;
      cin   = 1'b0;
      arith = 1'b0;
      case (ALU)
         ALU_ADD: begin op_b = b;    cin = 1'b0; arith = 1'b1; end
         ALU_SUB: begin op_b = ~b;   cin = 1'b1; arith = 1'b1; end
         ALU_INC: begin op_b = '0;   cin = 1'b1; arith = 1'b1; end
         ALU_DEC: begin op_b = '1;   cin = 1'b0; arith = 1'b1; end
         default: begin op_b = '0;   cin = 1'b0; arith = 1'b0; end
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};

   // ALU result; carry out doubles as "no borrow" for the subtracting ops
   always_comb begin
      alu_y = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      if (arith) begin
         alu_y = sum[WIDTH-1:0];
         alu_c = sum[WIDTH];
         alu_v = (a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else begin
         case (ALU)
            ALU_PASS: alu_y = a;
            ALU_AND:  alu_y = a & b;
            ALU_OR:   alu_y = a | b;
            ALU_NOT:  alu_y = ~a;
            default:  alu_y = a;
         endcase
      end
   end

   // Shifter applied to the ALU result
   always_comb begin
      sh_y = alu_y;
      case (SH)
         SH_SHL:  sh_y = {alu_y[WIDTH-2:0], 1'b0};
         SH_SHR:  sh_y = {1'b0, alu_y[WIDTH-1:1]};
         SH_ROR:  sh_y = {alu_y[0], alu_y[WIDTH-1:1]};
         default: sh_y = alu_y;
      endcase
   end

   assign wd = IE ? n_input : sh_y;

   // Next flags: only a datapath write-back (not an external load) updates them
   always_comb begin
      flags_d = flags_q;
      if (WE && !IE) begin
         flags_d[F_Z] = (sh_y == '0);
         flags_d[F_N] = sh_y[WIDTH-1];
         flags_d[F_C] = alu_c;
         flags_d[F_V] = alu_v;
      end
   end

   // Next output: capture port A on OE, strobe valid for exactly one cycle
   always_comb begin
      result_d       = result_q;
      result_valid_d = 1'b0;
      if (OE) begin
         result_d       = a;
         result_valid_d = 1'b1;
      end
   end

   // Status and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flags_q        <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         flags_q        <= flags_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign flags        = flags_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign n_is_0       = (a == '0);

endmodule

// File: tb/tb_dp_param.sv
// tb/tb_dp_param.sv - directed self-checking bench for dp_param (WIDTH=8, DEPTH=4)
module tb_dp_param;
   import dp_param_pkg::*;

   logic       clock;
   logic       reset_n;
   logic [7:0] n_input;
   logic       IE, WE, RAE, RBE, OE;
   logic [1:0] WA, RAA, RBA;
   logic [2:0] ALU;
   logic [1:0] SH;
   logic [7:0] result;
   logic       result_valid;
   logic       n_is_0;
   logic [3:0] flags;

   int n_cmp = 0;
   int n_err = 0;

   dp_param #(.WIDTH(8), .DEPTH(4)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .n_input     (n_input),
      .IE          (IE),
      .WE          (WE),
      .WA          (WA),
      .RAE         (RAE),
      .RAA         (RAA),
      .RBE         (RBE),
      .RBA         (RBA),
      .ALU         (ALU),
      .SH          (SH),
      .OE          (OE),
      .result      (result),
      .result_valid(result_valid),
      .n_is_0      (n_is_0),
      .flags       (flags)
   );

   initial clock = 1'b0;
   always #(HALF) clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      WE = 1'b0; IE = 1'b0; OE = 1'b0; RAE = 1'b1; RBE = 1'b1;
      ALU = ALU_PASS; SH = SH_PASS;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [1:0] r, input logic [7:0] v);
      idle();
      WE = 1'b1; IE = 1'b1; WA = r; n_input = v;
      tick();
      idle();
   endtask

   task automatic op(input logic [1:0] wa, input logic [1:0] ra, input logic [1:0] rb,
                     input logic [2:0] alu, input logic [1:0] sh);
      idle();
      WE = 1'b1; WA = wa; RAA = ra; RBA = rb; ALU = alu; SH = sh;
      tick();
      idle();
   endtask

   task automatic rd(input string tag, input logic [1:0] r, input logic [7:0] exp);
      idle();
      OE = 1'b1; RAA = r;
      tick();
      chk(tag, result, exp);
      chk({tag, "_vld"}, result_valid, 1'b1);
      idle();
   endtask

   initial begin
      n_input = '0; WA = '0; RAA = '0; RBA = '0;
      idle();
      reset_n = 1'b0;
      #(3*HALF);
      chk("rst_result", result, 8'h00);
      chk("rst_valid", result_valid, 1'b0);
      chk("rst_flags", flags, 4'b0000);
      chk("rst_nz_rae1", n_is_0, 1'b1);
      RAE = 1'b0; #1;
      chk("rst_nz_rae0", n_is_0, 1'b1);
      RAE = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // Load and read back
      load(2'd0, 8'd1); load(2'd1, 8'd3); load(2'd2, 8'd7); load(2'd3, 8'd15);
      rd("ld_r0", 2'd0, 8'd1);
      tick();
      chk("vld_drop", result_valid, 1'b0);
      rd("ld_r1", 2'd1, 8'd3);
      rd("ld_r2", 2'd2, 8'd7);
      rd("ld_r3", 2'd3, 8'd15);
      chk("ld_flags", flags, 4'b0000);

      // r0 = r0 + r3 = 16
      op(2'd0, 2'd0, 2'd3, ALU_ADD, SH_PASS);
      chk("add_flags", flags, 4'b0000);
      rd("add_r0", 2'd0, 8'd16);

      // 0x7F + 0x01 -> 0x80 : Z0 N1 C0 V1
      load(2'd1, 8'h7F); load(2'd2, 8'h01);
      op(2'd1, 2'd1, 2'd2, ALU_ADD, SH_PASS);
      chk("ovf_flags", flags, 4'b0101);
      rd("ovf_r1", 2'd1, 8'h80);

      // 0xFF + 1 -> 0x00 : Z1 N0 C1 V0
      load(2'd1, 8'hFF);
      op(2'd1, 2'd1, 2'd0, ALU_INC, SH_PASS);
      chk("inc_flags", flags, 4'b1010);
      rd("inc_r1", 2'd1, 8'h00);

      // Shifts of 0x81
      load(2'd0, 8'h81);
      op(2'd1, 2'd0, 2'd0, ALU_PASS, SH_ROR);
      chk("ror_flags", flags, 4'b0100);
      op(2'd2, 2'd0, 2'd0, ALU_PASS, SH_SHR);
      op(2'd3, 2'd0, 2'd0, ALU_PASS, SH_SHL);
      rd("ror_r1", 2'd1, 8'hC0);
      rd("shr_r2", 2'd2, 8'h40);
      rd("shl_r3", 2'd3, 8'h02);

      // 5 - 5 -> 0 : Z1 N0 C1 V0
      load(2'd2, 8'd5); load(2'd3, 8'd5);
      op(2'd0, 2'd2, 2'd3, ALU_SUB, SH_PASS);
      chk("sub_flags", flags, 4'b1010);
      RAA = 2'd0; #1;
      chk("sub_nz", n_is_0, 1'b1);
      RAA = 2'd2; #1;
      chk("nz_nonzero", n_is_0, 1'b0);
      rd("sub_r0", 2'd0, 8'h00);

      // WE=0 changes nothing
      idle();
      WE = 1'b0; IE = 1'b0; ALU = ALU_DEC; SH = SH_SHL; WA = 2'd2; RAA = 2'd2;
      tick();
      chk("hold_flags", flags, 4'b1010);
      rd("hold_r2", 2'd2, 8'd5);

      // Same-cycle WE+OE on r2: old value out, new value stored
      load(2'd2, 8'd7);
      idle();
      WE = 1'b1; IE = 1'b1; WA = 2'd2; n_input = 8'd9; OE = 1'b1; RAA = 2'd2;
      tick();
      chk("rdw_result", result, 8'd7);
      rd("rdw_r2", 2'd2, 8'd9);

      // Disabled read port
      idle();
      RAE = 1'b0; RAA = 2'd2; OE = 1'b1;
      #1;
      chk("rae0_nz", n_is_0, 1'b1);
      tick();
      chk("rae0_result", result, 8'h00);

      // Reset mid-ADD, between edges
      load(2'd1, 8'h11);
      op(2'd0, 2'd1, 2'd1, ALU_ADD, SH_SHL);
      rd("pre_rst_r1", 2'd1, 8'h11);
      idle();
      WE = 1'b1; WA = 2'd1; RAA = 2'd1; RBA = 2'd1; ALU = ALU_ADD;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mrst_result", result, 8'h00);
      chk("mrst_valid", result_valid, 1'b0);
      chk("mrst_flags", flags, 4'b0000);
      chk("mrst_nz", n_is_0, 1'b1);
      tick();
      idle();
      reset_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         rd($sformatf("mrst_r%0d", i), 2'(i), 8'h00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dp_param.md
# dp_param

Parametrised successor to the fixed 4×8 datapath used by the sum controller: a register file of `DEPTH` words of `WIDTH` bits, two enabled read ports, an ALU, a shifter and a registered output port. It now also carries latched status flags and a registered output with a valid strobe. It sits under a microcoded or FSM controller, which drives one control word per clock and samples `n_is_0` and the flags to branch.

## Interface
- `WIDTH`, 8, datapath and register word width (≥ 2)
- `DEPTH`, 4, number of registers (power of 2, ≥ 2); `AW = $clog2(DEPTH)`
- `clock` input 1: rising-edge clock
- `reset_n` input 1: asynchronous, active-low reset
- `n_input` input WIDTH: external data in
- `IE` input 1: write-back source select; 1 = `n_input`, 0 = shifter output
- `WE` input 1: register-file write enable
- `WA` input AW: write address
- `RAE`, `RBE` input 1: read-port A/B enables; a disabled port reads 0
- `RAA`, `RBA` input AW: read addresses
- `ALU` input 3: ALU opcode
- `SH` input 2: shifter opcode
- `OE` input 1: capture port A into the output register
- `result` output WIDTH: registered output
- `result_valid` output 1: one-cycle pulse, high in the cycle after an `OE` capture
- `n_is_0` output 1: combinational, high when port A == 0
- `flags` output 4: registered {Z, N, C, V}

## Operation
- Read ports are combinational: `A = RAE ? rf[RAA] : 0`, `B = RBE ? rf[RBA] : 0`.
- ALU (width WIDTH, plus carry out):
  - 000 pass A
  - 001 A&B
  - 010 A|B
  - 011 ~A
  - 100 A+B
  - 101 A−B (A + ~B + 1)
  - 110 A+1
  - 111 A−1
- Carry/borrow flag C:
  - Add ops: C = carry out.
  - Sub ops: C = 1 when no borrow.
  - Logic and pass ops: C = 0, V = 0.
- Overflow flag V: two's-complement overflow of the add or subtract.
- Shifter on the ALU result:
  - 00 pass
  - 01 logical left by 1
  - 10 logical right by 1
  - 11 rotate right by 1
- Write-back: when `WE` = 1, `rf[WA] <= IE ? n_input : shifter_out` on the clock edge.
- Flags update on every edge where `WE` = 1 and `IE` = 0:
  - Z = (shifter_out == 0)
  - N = shifter_out[WIDTH-1]
  - C and V come from the ALU (pre-shift).
  - Otherwise the flags hold.
- Output:
  - When `OE` = 1: `result <= A` on the edge and `result_valid <= 1`.
  - Otherwise `result` holds its value and `result_valid <= 0`.
- All wrap-around is modulo 2^WIDTH; no saturation.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) clears:
  - all rf words to 0
  - `flags` to 0000
  - `result` to 0
  - `result_valid` to 0
  - `n_is_0` then reads 1 when `RAE` = 1 (and also reads 1 when `RAE` = 0).
- Single-cycle op: a control word applied in cycle t writes `rf` and `flags` at the end of t.
- Read-during-write to the same address returns the old value; the new value is visible in t+1.
- `OE` is asserted with the read address in cycle t; `result` and `result_valid` are valid in t+1.
- Simultaneous `WE` and `OE` to the same register: `result` gets the old (pre-write) value.
- Reset asserted mid-sequence aborts the pending write and clears state immediately, with no clock needed.
- `WE` = 0 leaves every register and the flags unchanged, whatever `ALU`, `SH` or `IE` are set to.

## Structure
- A shared package/header holds:
  - `ALU_*` opcode constants (3 bits)
  - `SH_*` constants (2 bits)
  - flag bit indices `F_Z`, `F_N`, `F_C`, `F_V`
  - the `HALF` clock period used by benches
- One natural sub-module, `dp_regfile`: a parametrised `DEPTH`×`WIDTH` array with one synchronous write port, two enabled combinational read ports and async reset.
- ALU, shifter, flag and output logic stay in `dp_param`.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Load: write 1, 3, 7, 15 to r0..r3 (`IE`=1, `WE`=1); then read each with `OE` → `result` = 1, 3, 7, 15, `result_valid` pulses once per read, `flags` stay 0000.
- Add r0 + r3 → r0 (`ALU`=100, `SH`=00) → r0 = 16, flags Z=0, N=0, C=0, V=0; the next `OE` on r0 gives `result` = 16.
- Overflow and wrap: r1=0x7F, r2=0x01, ADD → 0x80 with N=1, V=1, C=0; r1=0xFF, INC → 0x00 with Z=1, C=1.
- Shift and compare:
  - r0=0x81 with `SH`=11 → 0xC0; `SH`=10 → 0x40; `SH`=01 on 0x81 → 0x02.
  - SUB with r2=r3=5 → 0 with Z=1, C=1.
  - `n_is_0` = 1 whenever port A reads 0.
- Boundaries:
  - Same-cycle `WE`+`OE` on r2 (old value 7, new value 9) → `result` = 7, r2 = 9.
  - `RAE`=0 → A reads 0 and `n_is_0` = 1.
- Reset mid-operation: drop `reset_n` between edges during an ADD → all registers, flags, `result` and `result_valid` are 0 immediately; the write does not occur.
